// File: rtl/axi_pkg.sv
// Shared AXI4 constants, the ARSIZE encoder and the read-DMA state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_4KB = 4096;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} rd_state_e;

  function automatic logic [2:0] size_of_bytes(input int bytes);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bytes == (1 << i)) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle with master and slave views.
interface axi_if #(
  parameter int P_A_BITWIDTH = 32,
  parameter int P_D_BITWIDTH = 32,
  parameter int P_I_BITWIDTH = 4,
  parameter int P_U_BITWIDTH = 1
) (
  input logic ACLK,
  input logic ARESETn
);

  logic [P_I_BITWIDTH-1:0]   AWID;
  logic [P_A_BITWIDTH-1:0]   AWADDR;
  logic [7:0]                AWLEN;
  logic [2:0]                AWSIZE;
  logic [1:0]                AWBURST;
  logic                      AWLOCK;
  logic [3:0]                AWCACHE;
  logic [2:0]                AWPROT;
  logic [3:0]                AWQOS;
  logic [3:0]                AWREGION;
  logic [P_U_BITWIDTH-1:0]   AWUSER;
  logic                      AWVALID;
  logic                      AWREADY;

  logic [P_D_BITWIDTH-1:0]   WDATA;
  logic [P_D_BITWIDTH/8-1:0] WSTRB;
  logic                      WLAST;
  logic [P_U_BITWIDTH-1:0]   WUSER;
  logic                      WVALID;
  logic                      WREADY;

  logic [P_I_BITWIDTH-1:0]   BID;
  logic [1:0]                BRESP;
  logic [P_U_BITWIDTH-1:0]   BUSER;
  logic                      BVALID;
  logic                      BREADY;

  logic [P_I_BITWIDTH-1:0]   ARID;
  logic [P_A_BITWIDTH-1:0]   ARADDR;
  logic [7:0]                ARLEN;
  logic [2:0]                ARSIZE;
  logic [1:0]                ARBURST;
  logic                      ARLOCK;
  logic [3:0]                ARCACHE;
  logic [2:0]                ARPROT;
  logic [3:0]                ARQOS;
  logic [3:0]                ARREGION;
  logic [P_U_BITWIDTH-1:0]   ARUSER;
  logic                      ARVALID;
  logic                      ARREADY;

  logic [P_I_BITWIDTH-1:0]   RID;
  logic [P_D_BITWIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic [P_U_BITWIDTH-1:0]   RUSER;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
           AWQOS, AWREGION, AWUSER, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WUSER, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
           ARQOS, ARREGION, ARUSER, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
           AWQOS, AWREGION, AWUSER, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WUSER, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
           ARQOS, ARREGION, ARUSER, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi_burst_calc.sv
// Next INCR burst length: limited by beats remaining, max burst and the 4 KB page edge.
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int P_D_BITWIDTH = 32,
  parameter int P_MAX_BURST  = 16,
  parameter int P_L_BITWIDTH = 16
) (
  input  logic [11:0]             addr_lo,
  input  logic [P_L_BITWIDTH-1:0] remaining,
  output logic [8:0]              blen
);

  localparam int SHIFT = $clog2(P_D_BITWIDTH / 8);

  logic [12:0] to_bound;
  logic [31:0] cap_w;
  logic [31:0] rem_w;

  always_comb begin
    to_bound = (13'(AXI_4KB) - {1'b0, addr_lo}) >> SHIFT;
    cap_w    = (32'(to_bound) < 32'(P_MAX_BURST)) ? 32'(to_bound) : 32'(P_MAX_BURST);
    rem_w    = 32'(remaining);
    blen     = 9'((rem_w < cap_w) ? rem_w : cap_w);
  end

endmodule

// File: rtl/axi_rd_dma.sv
// AXI4 read DMA: splits a (start address, beat count) command into INCR bursts
// and forwards returned data as a valid/ready stream with tlast on the final beat.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   ADDR  | AR request presented, waiting for ARREADY
//   DATA  | one burst in flight, R beats passed straight to the stream
//   DONE  | one-cycle completion pulse
module axi_rd_dma
  import axi_pkg::*;
#(
  parameter int P_A_BITWIDTH = 32,
  parameter int P_D_BITWIDTH = 32,
  parameter int P_I_BITWIDTH = 4,
  parameter int P_ARID       = 0,
  parameter int P_MAX_BURST  = 16,
  parameter int P_L_BITWIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [P_A_BITWIDTH-1:0] cmd_addr,
  input  logic [P_L_BITWIDTH-1:0] cmd_beats,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [P_D_BITWIDTH-1:0] m_tdata,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  axi_if.master                   m_axi
);

  localparam int BPB   = P_D_BITWIDTH / 8;
  localparam int SHIFT = $clog2(BPB);

  rd_state_e state, state_nxt;

  logic [P_A_BITWIDTH-1:0] addr;
  logic [P_L_BITWIDTH-1:0] remaining;
  logic [8:0]              beat_cnt;
  logic [8:0]              blen_q;
  logic [7:0]              ar_len_q;
  logic                    err_q;

  logic [11:0]             calc_addr_lo;
  logic [P_L_BITWIDTH-1:0] calc_rem;
  logic [8:0]              blen;
  logic                    cmd_hs, ar_hs, r_hs, last_beat;
  logic                    arvalid, rready;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign ar_hs     = (state == ADDR) && m_axi.ARREADY;
  assign r_hs      = (state == DATA) && m_axi.RVALID && m_tready;
  assign last_beat = (beat_cnt == 9'd1);

  // In IDLE the first burst is sized from the incoming command itself
  assign calc_addr_lo = (state == IDLE) ? cmd_addr[11:0] : addr[11:0];
  assign calc_rem     = (state == IDLE) ? cmd_beats : remaining;

  axi_burst_calc #(
    .P_D_BITWIDTH (P_D_BITWIDTH),
    .P_MAX_BURST  (P_MAX_BURST),
    .P_L_BITWIDTH (P_L_BITWIDTH)
  ) u_burst_calc (
    .addr_lo   (calc_addr_lo),
    .remaining (calc_rem),
    .blen      (blen)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET) state_nxt = (cmd_beats == '0) ? DONE : ADDR;
      end
      ADDR: begin
        arvalid = 1'b1;
        if (m_axi.ARREADY) state_nxt = DATA;
      end
      DATA: begin
        rready   = m_tready;
        m_tvalid = m_axi.RVALID;
        m_tlast  = last_beat && (remaining == '0);
        if (r_hs && last_beat) state_nxt = (remaining == '0) ? DONE : ADDR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      blen_q    <= '0;
      ar_len_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr      <= cmd_addr;
        remaining <= cmd_beats;
        err_q     <= 1'b0;
      end
      // Burst shape is frozen on ADDR entry so ARADDR/ARLEN cannot move under ARVALID
      if (state_nxt == ADDR && state != ADDR) begin
        blen_q   <= blen;
        ar_len_q <= 8'(blen - 9'd1);
      end
      if (ar_hs) begin
        beat_cnt  <= blen_q;
        addr      <= addr + (P_A_BITWIDTH'(blen_q) << SHIFT);
        remaining <= remaining - P_L_BITWIDTH'(blen_q);
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt - 9'd1;
        if (m_axi.RRESP != AXI_RESP_OKAY || m_axi.RLAST != last_beat) err_q <= 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign m_tdata = m_axi.RDATA;

  assign m_axi.AWID     = '0;
  assign m_axi.AWADDR   = '0;
  assign m_axi.AWLEN    = '0;
  assign m_axi.AWSIZE   = '0;
  assign m_axi.AWBURST  = '0;
  assign m_axi.AWLOCK   = 1'b0;
  assign m_axi.AWCACHE  = '0;
  assign m_axi.AWPROT   = '0;
  assign m_axi.AWQOS    = '0;
  assign m_axi.AWREGION = '0;
  assign m_axi.AWUSER   = '0;
  assign m_axi.AWVALID  = 1'b0;
  assign m_axi.WDATA    = '0;
  assign m_axi.WSTRB    = '0;
  assign m_axi.WLAST    = 1'b0;
  assign m_axi.WUSER    = '0;
  assign m_axi.WVALID   = 1'b0;
  assign m_axi.BREADY   = 1'b1;

  assign m_axi.ARID     = P_I_BITWIDTH'(P_ARID);
  assign m_axi.ARADDR   = addr;
  assign m_axi.ARLEN    = ar_len_q;
  assign m_axi.ARSIZE   = size_of_bytes(BPB);
  assign m_axi.ARBURST  = AXI_BURST_INCR;
  assign m_axi.ARLOCK   = 1'b0;
  assign m_axi.ARCACHE  = 4'b0011;
  assign m_axi.ARPROT   = '0;
  assign m_axi.ARQOS    = '0;
  assign m_axi.ARREGION = '0;
  assign m_axi.ARUSER   = '0;
  assign m_axi.ARVALID  = arvalid;
  assign m_axi.RREADY   = rready;

  logic unused_axi;
  assign unused_axi = ^{m_axi.AWREADY, m_axi.WREADY, m_axi.BID, m_axi.BRESP,
                        m_axi.BUSER, m_axi.BVALID, m_axi.RID, m_axi.RUSER};

  a_cmd_addr_aligned: assert property (@(posedge ACLK) disable iff (ARESET)
    cmd_hs |-> ((cmd_addr & P_A_BITWIDTH'(BPB - 1)) == '0));

endmodule

// File: tb/tb_axi_rd_dma.sv
// Directed bench for axi_rd_dma: command table against a simple AXI read slave.
module tb_axi_rd_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic        busy, done, err;

  always #5 clk = ~clk;

  axi_if #(.P_A_BITWIDTH(32), .P_D_BITWIDTH(32), .P_I_BITWIDTH(4)) bus (
    .ACLK(clk), .ARESETn(!rst)
  );

  axi_rd_dma #(
    .P_A_BITWIDTH(32), .P_D_BITWIDTH(32), .P_I_BITWIDTH(4),
    .P_ARID(0), .P_MAX_BURST(16), .P_L_BITWIDTH(16)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .busy(busy), .done(done), .err(err),
    .m_axi(bus)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      beats;
    logic             rnd;
    logic [7:0]       err_beat;
    logic             exp_err;
    logic [2:0]       n_ar;
    logic [2:0][31:0] ar_addr;
    logic [2:0][7:0]  ar_len;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_vec;

  // per-command observations
  int          n_ar, n_beat, n_last, last_pos, bad_data, done_cnt, arv_cnt;
  int          accept_cyc, last_beat_cyc, done_cyc, stab_bad, mirror_bad;
  logic        err_at_done;
  logic [31:0] ar_addr_log[8];
  logic [7:0]  ar_len_log[8];
  logic [31:0] cur_addr;
  bit          ar_wait;
  logic [31:0] h_addr;
  logic [7:0]  h_len;

  // slave model
  bit          rnd;
  int          err_beat, s_beat, r_left;
  bit          r_active;
  logic [31:0] r_addr;
  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input int beats, input bit r,
                              input int eb, input bit ee, input int nar,
                              input logic [31:0] a0, input int l0,
                              input logic [31:0] a1, input int l1,
                              input logic [31:0] a2, input int l2);
    vec_t v;
    v.addr       = a;
    v.beats      = 16'(beats);
    v.rnd        = r;
    v.err_beat   = 8'(eb);
    v.exp_err    = ee;
    v.n_ar       = 3'(nar);
    v.ar_addr[0] = a0;
    v.ar_addr[1] = a1;
    v.ar_addr[2] = a2;
    v.ar_len[0]  = 8'(l0);
    v.ar_len[1]  = 8'(l1);
    v.ar_len[2]  = 8'(l2);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0h want %0h", cur_vec, name, act, exp);
    end
  endtask

  task automatic clear_logs();
    n_ar = 0; n_beat = 0; n_last = 0; last_pos = -1; bad_data = 0; done_cnt = 0;
    arv_cnt = 0; accept_cyc = -100; last_beat_cyc = -100; done_cyc = -1000;
    stab_bad = 0; mirror_bad = 0; err_at_done = 1'bx; ar_wait = 0; s_beat = 0;
  endtask

  task automatic slave_drive();
    if (!r_active) bus.RVALID = 1'b0;
    else if (!bus.RVALID || (bus.RVALID && bus.RREADY)) bus.RVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // sample at negedge, then update slave/stream inputs just after posedge
  task automatic tick();
    bit s_ar, s_r, acc;
    @(negedge clk);
    cyc++;
    s_ar = bus.ARVALID && bus.ARREADY;
    s_r  = bus.RVALID && bus.RREADY;
    acc  = cmd_valid && cmd_ready;
    if (acc) accept_cyc = cyc;
    if (bus.ARVALID) arv_cnt++;
    if (s_ar) begin
      if (n_ar < 8) begin
        ar_addr_log[n_ar] = bus.ARADDR;
        ar_len_log[n_ar]  = bus.ARLEN;
      end
      n_ar++;
    end
    if (ar_wait && (!bus.ARVALID || bus.ARADDR !== h_addr || bus.ARLEN !== h_len)) stab_bad++;
    ar_wait = bus.ARVALID && !bus.ARREADY;
    h_addr  = bus.ARADDR;
    h_len   = bus.ARLEN;
    if (m_tvalid && (bus.RREADY !== m_tready || m_tdata !== bus.RDATA)) mirror_bad++;
    if (m_tvalid && m_tready) begin
      if (m_tdata !== mem(cur_addr + 32'(n_beat * 4))) bad_data++;
      if (m_tlast) begin
        n_last++;
        last_pos = n_beat;
      end
      n_beat++;
      last_beat_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      err_at_done = err;
    end
    @(posedge clk);
    #1;
    if (acc) cmd_valid = 1'b0;
    if (s_r) begin
      r_addr += 32'd4;
      r_left--;
      s_beat++;
      if (r_left == 0) r_active = 0;
    end
    if (s_ar) begin
      q_addr.push_back(h_addr);
      q_len.push_back(h_len);
    end
    if (!r_active && q_addr.size() > 0) begin
      r_addr   = q_addr.pop_front();
      r_left   = int'(q_len.pop_front()) + 1;
      r_active = 1;
    end
    slave_drive();
    bus.RDATA   = mem(r_addr);
    bus.RLAST   = (r_left == 1);
    bus.RRESP   = (s_beat == err_beat) ? 2'b10 : 2'b00;
    bus.ARREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    m_tready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int ref_cyc;
    clear_logs();
    cur_addr  = v.addr;
    rnd       = v.rnd;
    err_beat  = (v.err_beat == 8'hFF) ? -1 : int'(v.err_beat);
    cmd_addr  = v.addr;
    cmd_beats = v.beats;
    cmd_valid = 1'b1;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    ref_cyc = (v.beats != 0) ? last_beat_cyc : accept_cyc;
    check("n_ar", n_ar, v.n_ar);
    for (int i = 0; i < int'(v.n_ar) && i < n_ar; i++) begin
      check($sformatf("araddr%0d", i), ar_addr_log[i], v.ar_addr[i]);
      check($sformatf("arlen%0d", i), ar_len_log[i], v.ar_len[i]);
    end
    check("arvalid_seen", arv_cnt != 0, v.n_ar != 0);
    check("n_beat", n_beat, v.beats);
    check("data_bad", bad_data, 0);
    check("n_last", n_last, v.beats != 0);
    if (v.beats != 0) check("last_pos", last_pos, int'(v.beats) - 1);
    check("done_cnt", done_cnt, 1);
    check("done_lat", done_cyc - ref_cyc, 1);
    check("err_at_done", err_at_done, v.exp_err);
    check("err_held", err, v.exp_err);
    check("ar_stable", stab_bad, 0);
    check("rready_mirror", mirror_bad, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_addr = '0; cmd_beats = '0; m_tready = 1'b1;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = '0; bus.RLAST = 0;
    bus.RID = '0; bus.RUSER = '0; bus.AWREADY = 0; bus.WREADY = 0;
    bus.BVALID = 0; bus.BID = '0; bus.BRESP = '0; bus.BUSER = '0;
    rnd = 0; err_beat = -1; r_active = 0; r_left = 0; r_addr = '0;
    cur_vec = -1;

    vecs[0] = mk(32'h1000, 8,  0, 255, 0, 1, 32'h1000, 7, 32'h0, 0, 32'h0, 0);
    vecs[1] = mk(32'h0000, 40, 0, 255, 0, 3, 32'h0000, 15, 32'h0040, 15, 32'h0080, 7);
    vecs[2] = mk(32'h0FF0, 8,  0, 255, 0, 2, 32'h0FF0, 3, 32'h1000, 3, 32'h0, 0);
    vecs[3] = mk(32'h2000, 33, 1, 255, 0, 3, 32'h2000, 15, 32'h2040, 15, 32'h2080, 0);
    vecs[4] = mk(32'h3000, 8,  0, 2,   1, 1, 32'h3000, 7, 32'h0, 0, 32'h0, 0);
    vecs[5] = mk(32'h0500, 0,  0, 255, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    vecs[6] = mk(32'h1FF8, 5,  1, 255, 0, 2, 32'h1FF8, 1, 32'h2000, 2, 32'h0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_arvalid", bus.ARVALID, 0);
    check("awvalid", bus.AWVALID, 0);
    check("wvalid", bus.WVALID, 0);
    check("bready", bus.BREADY, 1);
    check("arsize", bus.ARSIZE, 2);
    check("arburst", bus.ARBURST, 1);
    check("arcache", bus.ARCACHE, 4'b0011);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // reset while a burst is streaming
    cur_vec = 7;
    clear_logs();
    rnd = 0; err_beat = -1;
    cur_addr = 32'h4000; cmd_addr = 32'h4000; cmd_beats = 16'd16; cmd_valid = 1'b1;
    for (int c = 0; c < 200 && n_beat < 3; c++) tick();
    check("pre_rst_beats", n_beat >= 3, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_slave_rvalid", bus.RVALID, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_arvalid", bus.ARVALID, 0);
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_rready", bus.RREADY, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_addr.delete();
    q_len.delete();
    r_active = 0;
    r_left = 0;
    bus.RVALID = 1'b0;
    cur_vec = 8;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
